// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// MULT/MULTU use a shift-add multiplier and DIV/DIVU use restoring division.
// Both perform one step per clock over WIDTH steps, followed by one sign-fix cycle.
// MTHI/MTLO write HI/LO directly from an idle unit.
//
// Handshake: start is sampled on an edge where busy=0. With a MULT/DIV op the
// operands are captured at that edge. done pulses for one cycle when the result
// lands in hi/lo, and start may be asserted again in that same cycle.
// A start while busy=1 is dropped.
module muldiv_unit #(
  parameter int WIDTH = 32,
  localparam int CNTW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             lo_zero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t            state, state_nx;
  logic [CNTW-1:0]   cnt;
  logic              is_div_q, neg_q, rem_neg_q, b_zero_q;
  logic [WIDTH-1:0]  a_q, mag_a_q, mag_b_q;
  // acc_hi: partial product high half / partial remainder.
  // acc_lo: multiplier bits shifting out / quotient bits shifting in.
  logic [WIDTH-1:0]  acc_hi, acc_lo;

  logic              accept, sgn, a_neg, b_neg;
  logic [WIDTH-1:0]  abs_a, abs_b;
  logic [WIDTH:0]    mul_sum, div_sh;
  logic [WIDTH+1:0]  div_diff;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]  quo_s, rem_s;

  // Operand capture: signed ops take magnitudes and remember the signs.
  always_comb begin
    accept = (state == S_IDLE) && start && !op[2];
    sgn    = !op[0];
    a_neg  = sgn && a[WIDTH-1];
    b_neg  = sgn && b[WIDTH-1];
    abs_a  = a_neg ? ('0 - a) : a;
    abs_b  = b_neg ? ('0 - b) : b;
  end

  // One iteration step for each operation, and the sign-corrected final results.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a_q} : '0);
    div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    div_diff = {1'b0, div_sh} - {2'b00, mag_b_q};
    prod     = {acc_hi, acc_lo};
    prod_s   = neg_q ? ('0 - prod) : prod;
    quo_s    = neg_q ? ('0 - acc_lo) : acc_lo;
    rem_s    = rem_neg_q ? ('0 - acc_hi) : acc_hi;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // FSM next-state logic: IDLE -> RUN for WIDTH steps -> FIX -> IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_RUN;
      S_RUN:   if (cnt == CNTW'(WIDTH - 1)) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy    = (state == S_RUN) || (state == S_FIX);
  assign lo_zero = (lo == '0);

  // Datapath: operand latch, iteration, result write-back, and MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= '0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      b_zero_q  <= 1'b0;
      a_q       <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            is_div_q  <= op[1];
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            b_zero_q  <= (b == '0);
            a_q       <= a;
            mag_a_q   <= abs_a;
            mag_b_q   <= abs_b;
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= op[1] ? abs_a : abs_b;
          end else if (start && op == 3'b100) begin
            hi <= a;
          end else if (start && op == 3'b101) begin
            lo <= a;
          end
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div_q) begin
            if (!div_diff[WIDTH+1]) acc_hi <= div_diff[WIDTH-1:0];
            else                    acc_hi <= div_sh[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], !div_diff[WIDTH+1]};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          done <= 1'b1;
          if (is_div_q && b_zero_q) begin
            lo <= '1;
            hi <= a_q;
          end else if (is_div_q) begin
            lo <= quo_s;
            hi <= rem_s;
          end else begin
            lo <= prod_s[WIDTH-1:0];
            hi <= prod_s[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, lo_zero;
  logic [W-1:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .lo_zero(lo_zero)
  );

  // Clock and time limit.
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, applied=%0d", n_vec);
    $fatal(1, "timeout");
  end

  // Driver: pulse start for the one edge E0.
  task automatic pulse_start(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Driver: count edges after E0 until done is seen (-1 when none within 40).
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (hi !== '0) begin n_err++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_vec++; if (lo !== '0) begin n_err++; $display("FAIL reset_lo: got %h want 0", lo); end
    n_vec++; if (lo_zero !== 1'b1) begin n_err++; $display("FAIL reset_lo_zero: got %b want 1", lo_zero); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // Table of MULT/DIV vectors with hand-computed results.
  task automatic test_arith;
    logic [2:0]   t_op [10];
    logic [W-1:0] t_a  [10];
    logic [W-1:0] t_b  [10];
    logic [W-1:0] t_hi [10];
    logic [W-1:0] t_lo [10];
    int lat;
    t_op[0]=3'b001; t_a[0]=32'd7;        t_b[0]=32'd6;        t_hi[0]=32'h0;        t_lo[0]=32'h0000002A;
    t_op[1]=3'b000; t_a[1]=32'hFFFFFFFD; t_b[1]=32'd5;        t_hi[1]=32'hFFFFFFFF; t_lo[1]=32'hFFFFFFF1;
    t_op[2]=3'b000; t_a[2]=32'h80000000; t_b[2]=32'h80000000; t_hi[2]=32'h40000000; t_lo[2]=32'h0;
    t_op[3]=3'b001; t_a[3]=32'hFFFFFFFF; t_b[3]=32'hFFFFFFFF; t_hi[3]=32'hFFFFFFFE; t_lo[3]=32'h00000001;
    t_op[4]=3'b010; t_a[4]=32'hFFFFFFF9; t_b[4]=32'd2;        t_hi[4]=32'hFFFFFFFF; t_lo[4]=32'hFFFFFFFD;
    t_op[5]=3'b010; t_a[5]=32'd7;        t_b[5]=32'hFFFFFFFE; t_hi[5]=32'h00000001; t_lo[5]=32'hFFFFFFFD;
    t_op[6]=3'b011; t_a[6]=32'hFFFFFFFF; t_b[6]=32'd16;       t_hi[6]=32'h0000000F; t_lo[6]=32'h0FFFFFFF;
    t_op[7]=3'b010; t_a[7]=32'd123;      t_b[7]=32'd0;        t_hi[7]=32'h0000007B; t_lo[7]=32'hFFFFFFFF;
    t_op[8]=3'b010; t_a[8]=32'hFFFFFF85; t_b[8]=32'd0;        t_hi[8]=32'hFFFFFF85; t_lo[8]=32'hFFFFFFFF;
    t_op[9]=3'b010; t_a[9]=32'h80000000; t_b[9]=32'hFFFFFFFF; t_hi[9]=32'h0;        t_lo[9]=32'h80000000;
    for (int i = 0; i < 10; i++) begin
      pulse_start(t_op[i], t_a[i], t_b[i]);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL arith%0d_busy: got %b want 1", i, busy); end
      wait_done(lat);
      n_vec++; if (lat != 33) begin n_err++; $display("FAIL arith%0d_latency: got %0d want 33", i, lat); end
      n_vec++; if (hi !== t_hi[i]) begin n_err++; $display("FAIL arith%0d_hi: got %h want %h", i, hi, t_hi[i]); end
      n_vec++; if (lo !== t_lo[i]) begin n_err++; $display("FAIL arith%0d_lo: got %h want %h", i, lo, t_lo[i]); end
      n_vec++; if (lo_zero !== (t_lo[i] == '0)) begin n_err++; $display("FAIL arith%0d_lo_zero: got %b want %b", i, lo_zero, (t_lo[i] == '0)); end
      @(posedge clk); #1;
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL arith%0d_done_pulse: got %b want 0", i, done); end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    pulse_start(3'b001, 32'd9, 32'd9);          // accepted at E0
    repeat (4) @(posedge clk);
    #1;
    op = 3'b011; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;                          // E5: must be ignored
    start = 1'b0;
    wait_done(lat);
    n_vec++; if (lat != 28) begin n_err++; $display("FAIL b2b_first_latency: got %0d want 28", lat); end
    n_vec++; if (hi !== 32'd0) begin n_err++; $display("FAIL b2b_first_hi: got %h want 0", hi); end
    n_vec++; if (lo !== 32'd81) begin n_err++; $display("FAIL b2b_first_lo: got %h want 51", lo); end
    // Start again in the done cycle.
    pulse_start(3'b011, 32'd100, 32'd7);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept_busy: got %b want 1", busy); end
    wait_done(lat);
    n_vec++; if (lat != 33) begin n_err++; $display("FAIL b2b_second_latency: got %0d want 33", lat); end
    n_vec++; if (lo !== 32'd14) begin n_err++; $display("FAIL b2b_second_lo: got %h want e", lo); end
    n_vec++; if (hi !== 32'd2) begin n_err++; $display("FAIL b2b_second_hi: got %h want 2", hi); end
    @(posedge clk); #1;
  endtask

  task automatic test_moves;
    pulse_start(3'b100, 32'h55, 32'h0);
    n_vec++; if (hi !== 32'h55) begin n_err++; $display("FAIL mthi_hi: got %h want 55", hi); end
    n_vec++; if (lo !== 32'd14) begin n_err++; $display("FAIL mthi_lo: got %h want e", lo); end
    n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mthi_ctrl: got done=%b busy=%b want 0 0", done, busy); end
    pulse_start(3'b101, 32'hA5A5_0000, 32'h0);
    n_vec++; if (lo !== 32'hA5A5_0000) begin n_err++; $display("FAIL mtlo_lo: got %h want a5a50000", lo); end
    n_vec++; if (hi !== 32'h55) begin n_err++; $display("FAIL mtlo_hi: got %h want 55", hi); end
    n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mtlo_ctrl: got done=%b busy=%b want 0 0", done, busy); end
    pulse_start(3'b110, 32'h1234, 32'h1);
    repeat (3) begin
      n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reserved_ctrl: got done=%b busy=%b want 0 0", done, busy); end
      @(posedge clk); #1;
    end
    n_vec++; if (hi !== 32'h55 || lo !== 32'hA5A5_0000) begin n_err++; $display("FAIL reserved_regs: got hi=%h lo=%h want 55 a5a50000", hi, lo); end
  endtask

  task automatic test_abort;
    bit seen_done = 0;
    pulse_start(3'b010, 32'd1000, 32'd3);       // E0
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;                               // sampled at E10
    @(posedge clk); #1;
    reset = 1'b1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b want 0", done); end
    n_vec++; if (hi !== '0 || lo !== '0) begin n_err++; $display("FAIL abort_regs: got hi=%h lo=%h want 0 0", hi, lo); end
    n_vec++; if (lo_zero !== 1'b1) begin n_err++; $display("FAIL abort_lo_zero: got %b want 1", lo_zero); end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1;
    end
    n_vec++; if (seen_done) begin n_err++; $display("FAIL abort_no_done: got done pulse want none"); end
  endtask

  initial begin
    test_reset;
    test_arith;
    test_back_to_back;
    test_moves;
    test_abort;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
